// File: rtl/mmio_pkg.sv
// Shared register map and STATUS layout for the MMIO responder page.
package mmio_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_DEPTH  = 8'h0C;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTL_CLR_OVF = 0;
    localparam int CTL_FLUSH   = 1;

    function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                                input logic ovf, input logic [7:0] cnt);
        logic [31:0] s;
        s                         = '0;
        s[ST_EMPTY]               = empty;
        s[ST_FULL]                = full;
        s[ST_OVF]                 = ovf;
        s[ST_CNT_LSB +: 8]        = cnt;
        return s;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Byte-wide transmit FIFO; a push while full is still accepted when a pop frees a slot that cycle.
module mmio_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// Top-page MMIO responder: TX FIFO, STATUS/control, free-running cycle counter, 1-cycle read data.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel_q,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit, wr_en, rd_en;
    logic [7:0]    offset;
    logic          push, pop, flush, clr_ovf, cyc_wr;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          unused_addr;

    assign unused_addr = ^addr[1:0];

    assign hit     = (addr[31:8] == BASE[31:8]);
    assign offset  = {addr[7:2], 2'b00};
    assign wr_en   = hit && mem_wr;
    assign rd_en   = hit && !mem_wr;

    assign push    = wr_en && (offset == OFF_TXDATA);
    assign cyc_wr  = wr_en && (offset == OFF_CYCLE);
    assign flush   = wr_en && (offset == OFF_STATUS) && wdata[CTL_FLUSH];
    assign clr_ovf = wr_en && (offset == OFF_STATUS) && wdata[CTL_CLR_OVF];

    // A handshake coinciding with reset is void.
    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready && !reset;

    mmio_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (wdata[7:0]),
        .pop   (pop),
        .flush (flush),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)
            ovf_d = 1'b0;
        else if (push && fifo_full && !pop)
            ovf_d = 1'b1;
    end

    assign cycle_d = cyc_wr ? wdata : cycle_q + 32'd1;

    // Reads sample pre-edge state, so STATUS/CYCLE show values before this cycle's updates.
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (offset)
                OFF_STATUS: rdata_d = pack_status(fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
                OFF_CYCLE:  rdata_d = cycle_q;
                OFF_DEPTH:  rdata_d = 32'(DEPTH);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            cycle_q <= '0;
            rdata_q <= '0;
            sel_q   <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
            rdata_q <= rdata_d;
            sel_q   <= hit;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder against a queue-based register-map model.
module tb_mmio_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        sel_q;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    mmio_responder #(.DEPTH(DEPTH), .BASE(32'hFFFF_FF00)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .mem_wr   (mem_wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .sel_q    (sel_q),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data)
    );

    // Reference model state
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cnt = '0;
    logic [31:0] exp_rdata = '0;
    logic        exp_sel = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic rdy, input logic rst);
        logic        h;
        logic [7:0]  off;
        logic        pop;
        logic [31:0] rd;
        addr = a; mem_wr = w; wdata = d; tx_ready = rdy; reset = rst;
        h   = (a[31:8] == 24'hFF_FFFF);
        off = {a[7:2], 2'b00};
        pop = (q.size() != 0) && rdy;
        rd  = 32'h0;
        if (h && !w) begin
            case (off)
                8'h04: rd = {16'h0, 8'(q.size()), 5'h0, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
                8'h08: rd = m_cnt;
                8'h0C: rd = DEPTH;
                default: rd = 32'h0;
            endcase
        end
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 32'h0;
            exp_rdata = 32'h0;
            exp_sel = 1'b0;
        end else begin
            exp_rdata = rd;
            exp_sel = h;
            if (h && w && off == 8'h00) begin
                if (pop) void'(q.pop_front());
                if (q.size() < DEPTH) q.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else if (h && w && off == 8'h04) begin
                if (d[1]) q.delete();
                else if (pop) void'(q.pop_front());
                if (d[0]) m_ovf = 1'b0;
            end else if (pop) begin
                void'(q.pop_front());
            end
            m_cnt = (h && w && off == 8'h08) ? d : m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_cmp++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h want=%h", rdata, 32'h0); end
        n_cmp++;
        if (sel_q !== 1'b0) begin n_fail++; $display("FAIL reset_sel got=%b want=0", sel_q); end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_txvalid got=%b want=0", tx_valid); end
        step(32'hFFFF_FF04, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got=%h want=%h", rdata, 32'h1); end
        n_cmp++;
        if (sel_q !== 1'b1) begin n_fail++; $display("FAIL reset_status_sel got=%b want=1", sel_q); end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_status_txvalid got=%b want=0", tx_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) step(32'hFFFF_FF00, 1'b1, 32'h41 + i, 1'b0, 1'b0);
        step(32'hFFFF_FF04, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_status got=%h want=%h", rdata, 32'h806); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d] got=%b/%h want=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_txvalid got=%b want=0", tx_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] last;
        step(32'hFFFF_FF04, 1'b1, 32'h3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(32'hFFFF_FF00, 1'b1, 32'h41 + i, 1'b0, 1'b0);
        step(32'hFFFF_FF00, 1'b1, 32'h55, 1'b1, 1'b0);
        n_cmp++;
        if (tx_data !== 8'h42) begin n_fail++; $display("FAIL fullpop_head got=%h want=42", tx_data); end
        step(32'hFFFF_FF04, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0000_0802) begin n_fail++; $display("FAIL fullpop_status got=%h want=%h", rdata, 32'h802); end
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            last = tx_data;
            step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (last !== 8'h55) begin n_fail++; $display("FAIL fullpop_tail got=%h want=55", last); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) step(32'hFFFF_FF00, 1'b1, 32'h60 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(32'hFFFF_FF04, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0000_0504) begin n_fail++; $display("FAIL flush_pre got=%h want=%h", rdata, 32'h504); end
        step(32'hFFFF_FF04, 1'b1, 32'h3, 1'b1, 1'b0);
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_txvalid got=%b want=0", tx_valid); end
        step(32'hFFFF_FF04, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_status got=%h want=%h", rdata, 32'h1); end
    endtask

    task automatic test_cycle();
        step(32'hFFFF_FF08, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(32'hFFFF_FF08, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap got=%h want=%h", rdata, 32'h0); end
        step(32'hFFFF_FF08, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h1) begin n_fail++; $display("FAIL cycle_next got=%h want=%h", rdata, 32'h1); end
    endtask

    task automatic test_decode();
        step(32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_q !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL decode_offpage got=%b/%h want=0/0", sel_q, rdata); end
        step(32'hFFFF_FF10, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_q !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL decode_unmapped got=%b/%h want=1/0", sel_q, rdata); end
        step(32'hFFFF_FF0E, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'd8) begin n_fail++; $display("FAIL decode_depth got=%h want=%h", rdata, 32'd8); end
        step(32'hFFFF_FF00, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0 || sel_q !== 1'b1) begin n_fail++; $display("FAIL decode_txread got=%b/%h want=1/0", sel_q, rdata); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(32'hFFFF_FF00, 1'b1, 32'h70 + i, 1'b0, 1'b0);
        step(32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_txvalid got=%b want=0", tx_valid); end
        step(32'hFFFF_FF08, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_cycle got=%h want=0", rdata); end
    endtask

    task automatic test_random();
        logic [7:0]  offs [6];
        logic [31:0] a, d;
        logic        w, r, rs;
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08;
        offs[3] = 8'h0C; offs[4] = 8'h10; offs[5] = 8'h40;
        for (int n = 0; n < 800; n++) begin
            a = {24'hFF_FFFF, offs[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom & 32'hFFFF_0FFF;
            if ($urandom_range(0, 2) == 0) a[7:0] = 8'h00;
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (a[7:2] == 6'h01) d[1] = ($urandom_range(0, 7) == 0);
            r  = 1'($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 149) == 0);
            step(a, w, d, r, rs);
            n_cmp++;
            if (rdata !== exp_rdata || sel_q !== exp_sel) begin
                n_fail++;
                $display("FAIL rand_read[%0d] got=%b/%h want=%b/%h", n, sel_q, rdata, exp_sel, exp_rdata);
            end
            n_cmp++;
            if (tx_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_txvalid[%0d] got=%b want=%b", n, tx_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (tx_data !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_txdata[%0d] got=%h want=%h", n, tx_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_full_pop();
        test_flush();
        test_cycle();
        test_decode();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
